// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared pipeline definitions for branch resolution: FSM states, default widths
// and the MIPS opcodes that decode uses to raise id_branch / id_jump.
package branch_redirect_ctrl_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REDIR = 2'd1,
      SLOT  = 2'd2
   } br_state_e;

   // Primary opcodes and SPECIAL funct codes for control transfers
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)
         cnt <= '0;
      else if (inc && !(&cnt))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch-resolution back end: registered PC redirect honouring the delay slot
// and stalls, sticky delay-slot transfer error, saturating branch statistics.
module branch_redirect_ctrl
   import branch_redirect_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_branch,
   input  logic              id_jump,
   input  logic              cond_taken,
   input  logic [ADDR_W-1:0] id_target,
   input  logic              stall,
   output logic              pc_redirect,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              ds_error,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  taken_cnt
);

   br_state_e state, state_nxt;
   logic      ctl, taken, accept_idle, slot_xfer;

   // A jump wins when both strobes are high, so cond_taken is ignored then
   assign ctl         = id_branch | id_jump;
   assign taken       = id_jump | (id_branch & cond_taken);
   assign accept_idle = (state == IDLE) && !stall;
   assign slot_xfer   = (state != IDLE) && !stall && ctl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_idle && ctl) state_nxt = taken ? REDIR : SLOT;
         REDIR:   if (!stall) state_nxt = IDLE;
         SLOT:    if (!stall) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Redirect comes straight from the state register: no path from cond_taken
   always_comb begin
      pc_redirect = (state == REDIR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         redirect_pc <= '0;
      else if (accept_idle && ctl && taken)
         redirect_pc <= id_target;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ds_error <= 1'b0;
      else if (slot_xfer)
         ds_error <= 1'b1;
   end

   sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .clr_n (rst_n),
      .inc   (accept_idle & ctl),
      .cnt   (branch_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
      .clk   (clk),
      .clr_n (rst_n),
      .inc   (accept_idle & ctl & taken),
      .cnt   (taken_cnt)
   );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: a behavioural model pushes the
// expected post-edge outputs per driven cycle; they are popped and compared.
module tb_branch_redirect_ctrl;

   logic        clk, rst_n;
   logic        id_branch, id_jump, cond_taken, stall;
   logic [31:0] id_target;
   logic        pc_redirect, ds_error;
   logic [31:0] redirect_pc;
   logic [15:0] branch_cnt, taken_cnt;
   logic        pc_redirect4, ds_error4;
   logic [31:0] redirect_pc4;
   logic [3:0]  branch_cnt4, taken_cnt4;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        pcr;
      logic [31:0] rpc;
      logic        ds;
      int          bc;
      int          tc;
   } exp_t;

   exp_t q[$];

   // Reference model state: 0 idle, 1 redirect, 2 delay slot
   int          m_state;
   logic [31:0] m_pc;
   logic        m_ds;
   int          m_bc, m_tc;

   branch_redirect_ctrl #(.ADDR_W(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_branch(id_branch), .id_jump(id_jump),
      .cond_taken(cond_taken), .id_target(id_target), .stall(stall),
      .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .ds_error(ds_error),
      .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
   );

   branch_redirect_ctrl #(.ADDR_W(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .id_branch(id_branch), .id_jump(id_jump),
      .cond_taken(cond_taken), .id_target(id_target), .stall(stall),
      .pc_redirect(pc_redirect4), .redirect_pc(redirect_pc4), .ds_error(ds_error4),
      .branch_cnt(branch_cnt4), .taken_cnt(taken_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_pc    = '0;
      m_ds    = 1'b0;
      m_bc    = 0;
      m_tc    = 0;
   endtask

   function automatic int sat(input int v, input int max);
      return (v > max) ? max : v;
   endfunction

   // Drive one cycle, predict the outputs after the edge, then compare
   task automatic step(input logic b, input logic j, input logic c,
                       input logic [31:0] tgt, input logic st, input string tag);
      logic ctl, tk;
      exp_t e;
      id_branch  = b;
      id_jump    = j;
      cond_taken = c;
      id_target  = tgt;
      stall      = st;
      ctl = b | j;
      tk  = j | (b & c);
      if (!st) begin
         if (m_state == 0) begin
            if (ctl) begin
               m_bc++;
               if (tk) begin
                  m_tc++;
                  m_pc    = tgt;
                  m_state = 1;
               end else begin
                  m_state = 2;
               end
            end
         end else begin
            if (ctl) m_ds = 1'b1;
            m_state = 0;
         end
      end
      e.pcr = (m_state == 1);
      e.rpc = m_pc;
      e.ds  = m_ds;
      e.bc  = m_bc;
      e.tc  = m_tc;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk({tag, ".pc_redirect"}, 64'(pc_redirect), 64'(e.pcr));
      chk({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(e.rpc));
      chk({tag, ".ds_error"},    64'(ds_error),    64'(e.ds));
      chk({tag, ".branch_cnt"},  64'(branch_cnt),  64'(sat(e.bc, 65535)));
      chk({tag, ".taken_cnt"},   64'(taken_cnt),   64'(sat(e.tc, 65535)));
      chk({tag, ".branch_cnt4"}, 64'(branch_cnt4), 64'(sat(e.bc, 15)));
      chk({tag, ".taken_cnt4"},  64'(taken_cnt4),  64'(sat(e.tc, 15)));
   endtask

   initial begin
      rst_n = 1'b0;
      id_branch = 0; id_jump = 0; cond_taken = 0; id_target = '0; stall = 0;
      model_reset();
      @(posedge clk); #1;
      chk("rst.pc_redirect", 64'(pc_redirect), 64'd0);
      chk("rst.redirect_pc", 64'(redirect_pc), 64'd0);
      chk("rst.ds_error",    64'(ds_error),    64'd0);
      chk("rst.branch_cnt",  64'(branch_cnt),  64'd0);
      chk("rst.taken_cnt",   64'(taken_cnt),   64'd0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Taken BEQ: one-cycle redirect
      step(1, 0, 1, 32'h0040_0100, 0, "beq_acc");
      step(0, 0, 0, 32'hdead_beef, 0, "beq_slot");
      step(0, 0, 0, 32'h0,         0, "beq_idle");

      // Taken BNE then 3 stall cycles: 4-cycle redirect window
      step(1, 0, 1, 32'h0040_0200, 0, "bne_acc");
      step(0, 0, 0, 32'h1111_1111, 1, "bne_st1");
      step(1, 0, 1, 32'h2222_2222, 1, "bne_st2");
      step(0, 0, 0, 32'h3333_3333, 1, "bne_st3");
      step(0, 0, 0, 32'h0,         0, "bne_go");
      step(0, 0, 0, 32'h0,         0, "bne_idle");

      // Not-taken BGTZ: delay slot, no redirect
      step(1, 0, 0, 32'h0040_0300, 0, "bgtz_acc");
      step(0, 0, 0, 32'h0,         1, "bgtz_slot_st");
      step(0, 0, 0, 32'h0,         0, "bgtz_slot");
      step(0, 0, 0, 32'h0,         0, "bgtz_idle");

      // Both strobes high with cond_taken=0 behaves as a taken jump
      step(1, 1, 0, 32'h0040_0400, 0, "both_acc");
      step(0, 0, 0, 32'h0,         0, "both_slot");

      // Jump with a taken BEQ in its delay slot
      step(0, 1, 0, 32'h0040_0500, 0, "jds_acc");
      step(1, 0, 1, 32'h0040_0600, 0, "jds_slot");
      step(0, 0, 0, 32'h0,         0, "jds_idle");
      step(0, 0, 0, 32'h0,         0, "jds_idle2");

      // Reset asserted mid-cycle during a stalled redirect
      step(1, 0, 1, 32'h0040_0700, 0, "rr_acc");
      stall = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      chk("rr.pc_redirect", 64'(pc_redirect), 64'd0);
      chk("rr.redirect_pc", 64'(redirect_pc), 64'd0);
      chk("rr.ds_error",    64'(ds_error),    64'd0);
      chk("rr.branch_cnt",  64'(branch_cnt),  64'd0);
      chk("rr.taken_cnt",   64'(taken_cnt),   64'd0);
      #2 rst_n = 1'b1;
      model_reset();
      step(0, 0, 0, 32'h0, 0, "rr_after1");
      step(0, 0, 0, 32'h0, 0, "rr_after2");

      // 20 taken accepts: 4-bit counters must saturate at 15
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 1, 32'h0041_0000 + 32'(i * 4), 0, "sat_acc");
         step(0, 0, 0, 32'h0, 0, "sat_slot");
      end
      chk("sat.branch_cnt4", 64'(branch_cnt4), 64'd15);
      chk("sat.taken_cnt4",  64'(taken_cnt4),  64'd15);
      chk("sat.branch_cnt",  64'(branch_cnt),  64'd20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Branch-resolution back end for the MIPS pipeline. It consumes the per-cycle taken/not-taken decision of the branch condition handler, together with the target computed in ID. It drives a registered PC redirect into the fetch PC mux, honouring the architectural delay slot and hazard-unit stalls. It also flags illegal control transfers in a delay slot and keeps saturating branch statistics.

## Interface
- ADDR_W, 32, width of PC and target.
- CNT_W, 16, width of statistics counters.

- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_branch  in  1  conditional branch (BEQ/BNE/BLEZ/BGTZ/REGIMM) in ID; same qualifier fed to the condition handler.
- id_jump  in  1  unconditional J/JAL/JR/JALR in ID.
- cond_taken  in  1  condition handler output for the ID instruction.
- id_target  in  ADDR_W  resolved branch/jump target.
- stall  in  1  hazard unit holds PC and IF/ID this cycle.
- pc_redirect  out  1  PC mux selects redirect_pc this cycle.
- redirect_pc  out  ADDR_W  captured target.
- ds_error  out  1  sticky; branch/jump found in a delay slot.
- branch_cnt  out  CNT_W  accepted control-transfer instructions.
- taken_cnt  out  CNT_W  accepted taken transfers.

## Operation
- Accept: ID cycle with stall=0. Nothing is sampled while stall=1; the instruction stays in ID and is re-evaluated.
- ctl = id_branch | id_jump. taken = id_jump | (id_branch & cond_taken). With both strobes high, treat as a jump.
- FSM states: IDLE, REDIR, SLOT.
- IDLE:
  - accepted ctl & taken → capture id_target into redirect_pc, go REDIR.
  - accepted ctl & !taken → go SLOT.
  - otherwise stay.
- REDIR: pc_redirect=1; the delay-slot instruction is in ID.
  - stall=1 → stay; pc_redirect and redirect_pc held.
  - stall=0 → redirect consumed, go IDLE.
- SLOT: no redirect; the delay slot is in ID.
  - stall=0 → go IDLE.
  - stall=1 → stay.
- Delay-slot check: in REDIR or SLOT with stall=0 and ctl=1:
  - set ds_error;
  - do not redirect, count, or capture id_target;
  - the delay-slot transfer is discarded.
- Counters increment only on accepts in IDLE:
  - branch_cnt += ctl;
  - taken_cnt += ctl & taken.
- Counters saturate at all-ones, never wrap.
- ds_error clears only on reset.

## Timing
- Reset (async, rst_n=0): state IDLE, pc_redirect=0, redirect_pc=0, ds_error=0, both counters 0. A pending redirect is dropped; no partial redirect after release.
- Latency: taken accept at cycle t → pc_redirect=1 at t+1 (registered output, no combinational path from cond_taken).
- pc_redirect stays high from t+1 through the first cycle with stall=0, inclusive. Minimum width is 1 cycle.
- redirect_pc is stable for the whole pc_redirect window. It is only updated on a taken accept in IDLE.
- Back-to-back taken branches cannot redirect twice: the second lies in the delay slot and raises ds_error.
- ds_error rises the cycle after the offending delay-slot accept.
- Counter values are visible the cycle after the accept.

## Structure
- Shared pipeline package:
  - FSM state enum {IDLE, REDIR, SLOT};
  - ADDR_W and CNT_W defaults;
  - opcode localparams already used by the decode/condition logic, so id_branch/id_jump generation stays consistent.
- One sub-module, sat_counter (CNT_W, inc, async active-low clear), instantiated twice for branch_cnt and taken_cnt.
- FSM, target register and ds_error live in the top.

## Test plan
- BEQ accepted with cond_taken=1, id_target=0x0040_0100, stall=0 → pc_redirect=1 for exactly one cycle next cycle, redirect_pc=0x0040_0100, branch_cnt=1, taken_cnt=1.
- Taken BNE followed by stall=1 for 3 cycles → pc_redirect high 4 cycles, redirect_pc constant; then back to IDLE.
- Not-taken BGTZ → pc_redirect stays 0, SLOT for one cycle, branch_cnt=1, taken_cnt=0.
- Jump immediately followed by BEQ in its delay slot with cond_taken=1 → exactly one redirect (jump target), ds_error=1, branch_cnt=1.
- rst_n pulsed low during REDIR → pc_redirect drops asynchronously; after release, no redirect, counters 0.
- CNT_W=4, 20 taken accepts → branch_cnt=taken_cnt=15, no wrap.
